// File: rtl/soc_bus_fabric.sv
// ----------------------------------------------------------------------------
// soc_bus_fabric
//
// Single-master, multi-slave interconnect for the PicoRV32 native memory bus.
// The master request is decoded against NUM_SLAVES base/mask windows. The
// lowest-index window wins when windows overlap. The request is registered
// onto a shared slave bus with a one-hot s_valid. The selected slave's response
// is returned to the master as a one-cycle m_ready strobe.
//
// An access that hits no window is answered by an internal error slave. That
// slave returns DEFAULT_RDATA and records the first offending address in the
// sticky err/err_addr pair.
//
// Optional feature (macro SOC_BUS_TIMEOUT_EN):
//   When the macro is defined, a request that waits TIMEOUT_CYCLES cycles
//   without s_ready is aborted. It is then answered like an unmapped access.
//   Without the macro, the fabric waits indefinitely for s_ready.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   m_valid/m_instr/m_addr/m_wdata/m_wstrb   master request (wstrb 0 = read)
//   m_ready/m_rdata      master response (m_rdata held between responses)
//   s_valid[N]           one-hot slave request
//   s_addr/s_wdata/s_wstrb/s_instr  shared slave request fields
//   s_rdata[32*N]/s_ready[N]        per-slave response
//   err/err_addr         sticky error flag and first erroring address
//   err_clr              synchronous clear of err/err_addr
// ----------------------------------------------------------------------------
module soc_bus_fabric #(
   parameter int                        NUM_SLAVES     = 4,
   parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {32'h4000_0000, 32'h2000_0000,
                                                          32'h1000_0000, 32'h0000_0000},
   parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {4{32'hF000_0000}},
   parameter logic [NUM_SLAVES-1:0]     NARROW_MASK    = 4'b1000,
   parameter logic [31:0]               DEFAULT_RDATA  = 32'hDEAD_BEEF,
   parameter int                        TIMEOUT_CYCLES = 256
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       m_valid,
   input  logic                       m_instr,
   input  logic [31:0]                m_addr,
   input  logic [31:0]                m_wdata,
   input  logic [3:0]                 m_wstrb,
   output logic                       m_ready,
   output logic [31:0]                m_rdata,
   output logic [NUM_SLAVES-1:0]      s_valid,
   output logic [31:0]                s_addr,
   output logic [31:0]                s_wdata,
   output logic [3:0]                 s_wstrb,
   output logic                       s_instr,
   input  logic [32*NUM_SLAVES-1:0]   s_rdata,
   input  logic [NUM_SLAVES-1:0]      s_ready,
   output logic                       err,
   output logic [31:0]                err_addr,
   input  logic                       err_clr
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   generate
      if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
         $error("soc_bus_fabric: invalid parameter configuration");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_RESP = 3'd2,
      S_ERR  = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t             state_reg;
   logic [IDX_W-1:0]   tgt_reg;
   logic [31:0]        req_addr_reg;   // original master address, kept for err_addr

   // ---------------------------------------------------------------------
   // Address decode and per-slave read data split
   // ---------------------------------------------------------------------
   logic [NUM_SLAVES-1:0] hit;
   logic [31:0]           rdata_arr [NUM_SLAVES];

   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign hit[gi]       = (m_addr & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32];
      assign rdata_arr[gi] = s_rdata[32*gi +: 32];
   end

   logic             hit_any;
   logic [IDX_W-1:0] hit_idx;

   // Scan from the top down so that the lowest matching index is written last.
   always_comb begin
      hit_any = |hit;
      hit_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (hit[i]) hit_idx = IDX_W'(i);
      end
   end

   // ---------------------------------------------------------------------
   // Byte-lane narrowing: the lowest enabled lane is moved down to lane 0.
   // The address is advanced to that byte.
   // ---------------------------------------------------------------------
   logic [1:0] lane;
   logic       narrow;

   always_comb begin
      lane = 2'd0;
      casez (m_wstrb)
         4'b???1: lane = 2'd0;
         4'b??10: lane = 2'd1;
         4'b?100: lane = 2'd2;
         4'b1000: lane = 2'd3;
         default: lane = 2'd0;
      endcase
      narrow = hit_any && NARROW_MASK[hit_idx] && (m_wstrb != 4'b0000);
   end

`ifdef SOC_BUS_TIMEOUT_EN
   localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_cnt_reg;
`endif

   // ---------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= S_IDLE;
         tgt_reg      <= '0;
         req_addr_reg <= '0;
         s_valid      <= '0;
         s_addr       <= '0;
         s_wdata      <= '0;
         s_wstrb      <= '0;
         s_instr      <= 1'b0;
         m_ready      <= 1'b0;
         m_rdata      <= '0;
         err          <= 1'b0;
         err_addr     <= '0;
`ifdef SOC_BUS_TIMEOUT_EN
         tmo_cnt_reg  <= '0;
`endif
      end else begin
         // A new error captured in ERR below overrides this clear.
         if (err_clr) begin
            err      <= 1'b0;
            err_addr <= '0;
         end

         case (state_reg)
            S_IDLE: begin
               if (m_valid) begin
                  tgt_reg      <= hit_idx;
                  req_addr_reg <= m_addr;
                  s_instr      <= m_instr;
                  if (narrow) begin
                     s_addr  <= m_addr + {30'd0, lane};
                     s_wdata <= m_wdata >> {lane, 3'b000};
                     s_wstrb <= 4'b0001;
                  end else begin
                     s_addr  <= m_addr;
                     s_wdata <= m_wdata;
                     s_wstrb <= m_wstrb;
                  end
                  if (hit_any) begin
                     s_valid   <= NUM_SLAVES'(1) << hit_idx;
                     state_reg <= S_REQ;
`ifdef SOC_BUS_TIMEOUT_EN
                     tmo_cnt_reg <= '0;
`endif
                  end else begin
                     // Unmapped: nothing reaches a slave, so writes are dropped.
                     state_reg <= S_ERR;
                  end
               end
            end

            S_REQ: begin
               if (s_ready[tgt_reg]) begin
                  m_rdata   <= rdata_arr[tgt_reg];
                  m_ready   <= 1'b1;
                  s_valid   <= '0;
                  state_reg <= S_RESP;
               end
`ifdef SOC_BUS_TIMEOUT_EN
               // s_ready on the expiry cycle takes the branch above.
               else if (tmo_cnt_reg == TMO_LAST) begin
                  s_valid   <= '0;
                  state_reg <= S_ERR;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
`endif
            end

            S_RESP: begin
               m_ready   <= 1'b0;
               state_reg <= S_GAP;
            end

            S_ERR: begin
               // The error response becomes visible in the GAP cycle.
               m_ready <= 1'b1;
               m_rdata <= DEFAULT_RDATA;
               if (!err || err_clr) begin
                  err      <= 1'b1;
                  err_addr <= req_addr_reg;
               end
               state_reg <= S_GAP;
            end

            S_GAP: begin
               // The master drops m_valid in this cycle, so it is not sampled here.
               m_ready   <= 1'b0;
               state_reg <= S_IDLE;
            end

            default: begin
               m_ready   <= 1'b0;
               s_valid   <= '0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// ----------------------------------------------------------------------------
// tb_soc_bus_fabric
//
// Directed testbench for soc_bus_fabric with the default address map:
//   slave0 0x0xxx_xxxx, slave1 0x1xxx_xxxx, slave2 0x2xxx_xxxx,
//   slave3 0x4xxx_xxxx (narrow).
// TIMEOUT_CYCLES is set to 16. That value only matters when
// SOC_BUS_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_soc_bus_fabric;

   logic         clk;
   logic         resetn;
   logic         m_valid;
   logic         m_instr;
   logic [31:0]  m_addr;
   logic [31:0]  m_wdata;
   logic [3:0]   m_wstrb;
   logic         m_ready;
   logic [31:0]  m_rdata;
   logic [3:0]   s_valid;
   logic [31:0]  s_addr;
   logic [31:0]  s_wdata;
   logic [3:0]   s_wstrb;
   logic         s_instr;
   logic [127:0] s_rdata;
   logic [3:0]   s_ready;
   logic         err;
   logic [31:0]  err_addr;
   logic         err_clr;

   int checks   = 0;
   int failures = 0;

   soc_bus_fabric #(
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .m_valid  (m_valid),
      .m_instr  (m_instr),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_wstrb  (m_wstrb),
      .m_ready  (m_ready),
      .m_rdata  (m_rdata),
      .s_valid  (s_valid),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_wstrb  (s_wstrb),
      .s_instr  (s_instr),
      .s_rdata  (s_rdata),
      .s_ready  (s_ready),
      .err      (err),
      .err_addr (err_addr),
      .err_clr  (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Mapped transfer. Call it in an IDLE cycle; it returns in the next IDLE cycle.
   // m_valid stays high through RESP and GAP.
   task automatic xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [3:0] exp_sv,
                       input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [3:0] exp_wstrb, input int waits, input logic [31:0] rdata);
      m_valid = 1'b1;
      m_addr  = addr;
      m_wdata = wdata;
      m_wstrb = wstrb;
      for (int i = 0; i < 4; i++) s_rdata[32*i +: 32] = exp_sv[i] ? rdata : ~rdata;
      tick();
      for (int w = 0; w < waits; w++) begin
         chk({tag, " s_valid wait"}, {28'd0, s_valid}, {28'd0, exp_sv});
         s_ready = ~exp_sv;            // other slaves' ready must be ignored
         tick();
      end
      chk({tag, " s_valid"}, {28'd0, s_valid}, {28'd0, exp_sv});
      chk({tag, " s_addr"}, s_addr, exp_addr);
      chk({tag, " s_wdata"}, s_wdata, exp_wdata);
      chk({tag, " s_wstrb"}, {28'd0, s_wstrb}, {28'd0, exp_wstrb});
      chk({tag, " m_ready early"}, {31'd0, m_ready}, 32'd0);
      s_ready = exp_sv;
      tick();                           // RESP
      s_ready = 4'b0000;
      chk({tag, " m_ready"}, {31'd0, m_ready}, 32'd1);
      chk({tag, " m_rdata"}, m_rdata, rdata);
      chk({tag, " s_valid dropped"}, {28'd0, s_valid}, 32'd0);
      tick();                           // GAP, m_valid still held
      chk({tag, " m_ready gap"}, {31'd0, m_ready}, 32'd0);
      chk({tag, " m_rdata hold"}, m_rdata, rdata);
      tick();                           // IDLE
      chk({tag, " no dup s_valid"}, {28'd0, s_valid}, 32'd0);
      m_valid = 1'b0;
      $display("xfer %s addr=%h wstrb=%b rdata=%h", tag, addr, wstrb, m_rdata);
   endtask

   // Unmapped access: ERR at cycle 1, response at cycle 2, IDLE at cycle 3.
   task automatic err_xfer(input string tag, input logic [31:0] addr,
                           input logic clr, input logic [31:0] exp_err_addr);
      m_valid = 1'b1;
      m_addr  = addr;
      m_wstrb = 4'b0000;
      tick();                           // ERR
      chk({tag, " s_valid"}, {28'd0, s_valid}, 32'd0);
      chk({tag, " m_ready early"}, {31'd0, m_ready}, 32'd0);
      err_clr = clr;
      tick();                           // response cycle
      err_clr = 1'b0;
      chk({tag, " m_ready"}, {31'd0, m_ready}, 32'd1);
      chk({tag, " m_rdata"}, m_rdata, 32'hDEAD_BEEF);
      chk({tag, " err"}, {31'd0, err}, 32'd1);
      chk({tag, " err_addr"}, err_addr, exp_err_addr);
      m_valid = 1'b0;
      tick();                           // IDLE
      chk({tag, " m_ready end"}, {31'd0, m_ready}, 32'd0);
      $display("err_xfer %s addr=%h err_addr=%h", tag, addr, err_addr);
   endtask

   initial begin
      resetn  = 1'b0;
      m_valid = 1'b0;
      m_instr = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_wstrb = '0;
      s_rdata = '0;
      s_ready = '0;
      err_clr = 1'b0;

      // Reset state
      #12;
      chk("rst s_valid", {28'd0, s_valid}, 32'd0);
      chk("rst m_ready", {31'd0, m_ready}, 32'd0);
      chk("rst m_rdata", m_rdata, 32'd0);
      chk("rst err", {31'd0, err}, 32'd0);
      chk("rst err_addr", err_addr, 32'd0);
      chk("rst s_addr", s_addr, 32'd0);
      #10 resetn = 1'b1;
      tick();

      // Read slave 1 with 2 wait cycles; instr flag passes through.
      m_instr = 1'b1;
      xfer("rd_s1", 32'h1000_0010, 32'h0, 4'b0000, 4'b0010,
           32'h1000_0010, 32'h0, 4'b0000, 2, 32'hCAFE_0001);
      chk("rd_s1 s_instr", {31'd0, s_instr}, 32'd1);
      chk("rd_s1 err", {31'd0, err}, 32'd0);
      m_instr = 1'b0;

      // Back-to-back: minimum-latency read of slave 2.
      xfer("rd_s2", 32'h2000_0010, 32'h0, 4'b0000, 4'b0100,
           32'h2000_0010, 32'h0, 4'b0000, 0, 32'h1234_5678);

      // Byte write to the narrow slave 3: lane 2 is moved to lane 0.
      xfer("wr_s3_narrow", 32'h4000_0020, 32'h00AB_0000, 4'b0100, 4'b1000,
           32'h4000_0022, 32'h0000_00AB, 4'b0001, 0, 32'h0000_0000);
      // Half-word write to slave 3: the lowest lane (1) is selected.
      xfer("wr_s3_half", 32'h4000_0040, 32'h1122_3344, 4'b0110, 4'b1000,
           32'h4000_0041, 32'h0011_2233, 4'b0001, 1, 32'h0000_0005);
      // The same byte write to slave 1 passes through unchanged.
      xfer("wr_s1_pass", 32'h1000_0020, 32'h00AB_0000, 4'b0100, 4'b0010,
           32'h1000_0020, 32'h00AB_0000, 4'b0100, 1, 32'h0000_0007);
      // Read of the narrow slave is not narrowed.
      xfer("rd_s3", 32'h4000_0008, 32'h0, 4'b0000, 4'b1000,
           32'h4000_0008, 32'h0, 4'b0000, 0, 32'hA5A5_0003);

      // Unmapped accesses and the sticky error flag
      err_xfer("unmap1", 32'h8000_0000, 1'b0, 32'h8000_0000);
      err_xfer("unmap2", 32'h9000_0000, 1'b0, 32'h8000_0000);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr err", {31'd0, err}, 32'd0);
      chk("err_clr err_addr", err_addr, 32'd0);
      // Set wins over a coincident clear.
      err_xfer("unmap3", 32'h8000_0000, 1'b0, 32'h8000_0000);
      err_xfer("unmap_clr", 32'hA000_0000, 1'b1, 32'hA000_0000);

      // Asynchronous reset while in REQ
      m_valid = 1'b1;
      m_addr  = 32'h0000_0100;
      m_wstrb = 4'b0000;
      tick();
      chk("arst pre s_valid", {28'd0, s_valid}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("arst s_valid", {28'd0, s_valid}, 32'd0);
      chk("arst m_ready", {31'd0, m_ready}, 32'd0);
      chk("arst err", {31'd0, err}, 32'd0);
      m_valid = 1'b0;
      #3 resetn = 1'b1;
      tick();
      xfer("after_rst", 32'h0000_0100, 32'h0, 4'b0000, 4'b0001,
           32'h0000_0100, 32'h0, 4'b0000, 1, 32'h0BAD_F00D);

`ifdef SOC_BUS_TIMEOUT_EN
      // Slave 0 never answers: s_valid is high for 16 cycles.
      m_valid = 1'b1;
      m_addr  = 32'h0000_0200;
      tick();
      for (int c = 1; c <= 16; c++) begin
         chk("tmo s_valid", {28'd0, s_valid}, 32'd1);
         tick();
      end
      chk("tmo s_valid drop", {28'd0, s_valid}, 32'd0);
      chk("tmo m_ready early", {31'd0, m_ready}, 32'd0);
      tick();
      chk("tmo m_ready", {31'd0, m_ready}, 32'd1);
      chk("tmo m_rdata", m_rdata, 32'hDEAD_BEEF);
      chk("tmo err", {31'd0, err}, 32'd1);
      chk("tmo err_addr", err_addr, 32'h0000_0200);
      m_valid = 1'b0;
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      $display("timeout abort addr=%h", 32'h0000_0200);
      // s_ready on the expiry cycle wins.
      xfer("tmo_edge", 32'h0000_0300, 32'h0, 4'b0000, 4'b0001,
           32'h0000_0300, 32'h0, 4'b0000, 15, 32'h5555_AAAA);
      chk("tmo_edge err", {31'd0, err}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
